// File: rtl/dot_result_streamer_if.sv
// dot_result_streamer_if: single-word valid/ready result stream.
// master drives data and flags; slave returns ready.
interface dot_result_streamer_if #(
  parameter int Data_Width_Out = 16
);
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;
  logic [Data_Width_Out-1:0] out_data;

  modport master (
    output out_valid,
    output out_last,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_last,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/dot_result_streamer.sv
// dot_result_streamer: drains the output SRAM row by row onto a word stream.
// Define STREAM_CHECKSUM_EN to add a modular sum of all sent words.
module dot_result_streamer #(
  parameter int Addr_Width     = 4,
  parameter int Nums_Rows      = 8,
  parameter int Para_Deg       = 2,
  parameter int Data_Width_Out = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               mem_en_read,
  output logic [Addr_Width-1:0]              mem_read_addr,
  input  logic [Para_Deg*Data_Width_Out-1:0] mem_read_data,
  dot_result_streamer_if.master              strm
`ifdef STREAM_CHECKSUM_EN
  ,
  output logic [Data_Width_Out-1:0]          checksum
`endif
);

  localparam int Lane_W = (Para_Deg > 1) ? $clog2(Para_Deg) : 1;
  localparam int Row_Bits = Para_Deg * Data_Width_Out;
  localparam logic [Addr_Width-1:0] Last_Row =
    Addr_Width'(Nums_Rows - 1);
  localparam logic [Lane_W-1:0] Last_Lane =
    Lane_W'(Para_Deg - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DONE
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [Addr_Width-1:0]     row_q;
  logic [Addr_Width-1:0]     row_d;
  logic [Lane_W-1:0]         lane_q;
  logic [Lane_W-1:0]         lane_d;
  logic [Row_Bits-1:0]       row_buf;
  logic [Row_Bits-1:0]       buf_d;
  logic [Data_Width_Out-1:0] word_d;
  logic                      hs;

  // SEND always has out_valid high, so ready alone completes a beat
  assign hs = (state_q == SEND) && strm.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    lane_d  = lane_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          row_d   = '0;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        state_d = SEND;
        lane_d  = '0;
      end
      SEND: begin
        if (hs) begin
          if (lane_q != Last_Lane) begin
            lane_d = lane_q + Lane_W'(1);
          end else if (row_q != Last_Row) begin
            row_d   = row_q + Addr_Width'(1);
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // the row arriving from the SRAM bypasses the buffer for lane 0
  always_comb begin
    buf_d  = (state_q == WAIT) ? mem_read_data : row_buf;
    word_d = '0;
    for (int i = 0; i < Para_Deg; i++) begin
      if (lane_d == Lane_W'(i)) begin
        word_d = buf_d[i*Data_Width_Out +: Data_Width_Out];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_buf       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_en_read   <= 1'b0;
      mem_read_addr <= '0;
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
      strm.out_last  <= 1'b0;
    end else begin
      if (state_q == WAIT) begin
        row_buf <= mem_read_data;
      end
      busy        <= (state_d != IDLE);
      done        <= (state_d == DONE);
      mem_en_read <= (state_d == READ);
      if (state_d == READ) begin
        mem_read_addr <= row_d;
      end else if (state_d == IDLE) begin
        mem_read_addr <= '0;
      end
      strm.out_valid <= (state_d == SEND);
      strm.out_data  <= (state_d == SEND) ? word_d : '0;
      strm.out_last  <= (state_d == SEND) &&
                        (row_d == Last_Row) &&
                        (lane_d == Last_Lane);
    end
  end

`ifdef STREAM_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if ((state_q == IDLE) && start) begin
      checksum <= '0;
    end else if (hs) begin
      checksum <= checksum + strm.out_data;
    end
  end
`endif

endmodule

// File: tb/tb_dot_result_streamer.sv
// tb_dot_result_streamer: directed and random drains against a queue model.
// Also covers a one-row, four-lane instance.
module tb_dot_result_streamer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic        busy, done, en;
  logic [3:0]  addr;
  logic [31:0] rdata;
  logic        busy1, done1, en1;
  logic [3:0]  addr1;
  logic [63:0] rdata1;
  logic [31:0] mem [16];
  logic [63:0] row1;
`ifdef STREAM_CHECKSUM_EN
  logic [15:0] cks0, cks1;
`endif

  int checks = 0;
  int failures = 0;

  dot_result_streamer_if #(.Data_Width_Out(16)) s0 ();
  dot_result_streamer_if #(.Data_Width_Out(16)) s1 ();

  dot_result_streamer u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .mem_en_read   (en),
    .mem_read_addr (addr),
    .mem_read_data (rdata),
    .strm          (s0)
`ifdef STREAM_CHECKSUM_EN
    ,
    .checksum      (cks0)
`endif
  );

  dot_result_streamer #(
    .Addr_Width     (4),
    .Nums_Rows      (1),
    .Para_Deg       (4),
    .Data_Width_Out (16)
  ) u_one (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start1),
    .busy          (busy1),
    .done          (done1),
    .mem_en_read   (en1),
    .mem_read_addr (addr1),
    .mem_read_data (rdata1),
    .strm          (s1)
`ifdef STREAM_CHECKSUM_EN
    ,
    .checksum      (cks1)
`endif
  );

  always #5 clk = ~clk;

  // synchronous-read SRAM models: data one cycle after enable
  always_ff @(posedge clk) if (en) rdata <= mem[addr];
  always_ff @(posedge clk) if (en1) rdata1 <= row1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_valid"}, s0.out_valid, 0);
    chk({tag, "_data"}, s0.out_data, 0);
    chk({tag, "_last"}, s0.out_last, 0);
`ifdef STREAM_CHECKSUM_EN
    chk({tag, "_cks"}, cks0, 0);
`endif
  endtask

  // mode 0: ready held; 1: random ready; 2: stall word 3 then toggle
  task automatic run_drain(input int mode, input bit poke,
                           input string tag);
    logic [15:0] exp_q[$];
    logic [3:0]  addr_q[$];
    logic [15:0] held, sum, exp_w;
    bit          held_v, tog, rdy;
    int          n, stall, t_first, t_last, t_done, t_idle, n_done;
    sum = '0;
    for (int r = 0; r < 8; r++) begin
      for (int l = 0; l < 2; l++) begin
        exp_q.push_back(mem[r][l*16 +: 16]);
        sum = sum + mem[r][l*16 +: 16];
      end
    end
    held = '0; held_v = 0; tog = 1; n = 0; stall = 0;
    t_first = -1; t_last = -1; t_done = -1; t_idle = -1; n_done = 0;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 400; k++) begin
      start = 1'b0;
      if (en) addr_q.push_back(addr);
      if (s0.out_valid && t_first < 0) t_first = k;
      if (held_v) begin
        chk({tag, "_hold_valid"}, s0.out_valid, 1);
        chk({tag, "_hold_data"}, s0.out_data, held);
      end
      rdy = 1;
      if (mode == 1) rdy = 1'($urandom_range(0, 1));
      if (mode == 2) begin
        if (s0.out_valid && n == 3 && stall < 5) begin
          rdy = 0;
          stall++;
        end else if (stall >= 5) begin
          rdy = tog;
          tog = !tog;
        end
      end
      s0.out_ready = rdy;
      if (s0.out_valid && rdy) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk({tag, "_data"}, s0.out_data, exp_w);
        chk({tag, "_last"}, s0.out_last, exp_q.size() == 0);
        n++;
        if (n == 16) t_last = k;
        held_v = 0;
      end else begin
        held_v = s0.out_valid;
        held = s0.out_data;
      end
      if (done) begin
        n_done++;
        if (t_done < 0) t_done = k;
`ifdef STREAM_CHECKSUM_EN
        chk({tag, "_checksum"}, cks0, sum);
`endif
        if (poke) start = 1'b1;
      end
      if (poke && k == 6) start = 1'b1;
      if (k > 0 && !busy) begin
        t_idle = k;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    s0.out_ready = 1'b0;
    chk({tag, "_words"}, n, 16);
    chk({tag, "_first_valid"}, t_first, 2);
    chk({tag, "_done_cnt"}, n_done, 1);
    if (mode == 0) chk({tag, "_last_hs"}, t_last, 31);
    chk({tag, "_done_at"}, t_done, t_last + 1);
    chk({tag, "_busy_fall"}, t_idle, t_done + 1);
    chk({tag, "_nreads"}, addr_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_addr"}, (i < addr_q.size()) ? addr_q[i] : 4'hx, i);
    end
    repeat (2) @(negedge clk);
    chk({tag, "_stays_idle"}, busy, 0);
  endtask

  initial begin
    int          n, t_done, lastpos;
    logic [15:0] sum1;
    s0.out_ready = 1'b0;
    s1.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    row1 = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 8; r++) mem[r] = {16'(2*r+1), 16'(2*r)};
    run_drain(0, 0, "full");
    run_drain(2, 0, "bp");
    run_drain(0, 1, "ignore");
    repeat (3) begin
      for (int r = 0; r < 8; r++) mem[r] = $urandom;
      run_drain(1, 0, "rand");
    end
    for (int r = 0; r < 8; r++) mem[r] = 32'hFFFF_FFFF;
    run_drain(0, 0, "ones");
`ifdef STREAM_CHECKSUM_EN
    chk("ones_cks_hold", cks0, 16'hFFF0);
`endif

    for (int r = 0; r < 8; r++) mem[r] = $urandom | 32'h0001_0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s0.out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (s0.out_valid && n == 6) break;
      if (s0.out_valid) n++;
      @(negedge clk);
    end
    chk("rst_reach_word6", n, 6);
    reset_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    s0.out_ready = 1'b0;
    @(negedge clk);
    run_drain(0, 0, "after_rst");

    row1 = {$urandom, $urandom};
    sum1 = row1[15:0] + row1[31:16] + row1[47:32] + row1[63:48];
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    s1.out_ready = 1'b1;
    n = 0; t_done = -1; lastpos = -1;
    for (int k = 0; k < 50; k++) begin
      if (en1) chk("one_addr", addr1, 0);
      if (s1.out_valid) begin
        chk("one_data", s1.out_data, (n < 4) ? row1[n*16 +: 16] : 16'hx);
        if (s1.out_last) lastpos = n;
        n++;
      end
      if (done1 && t_done < 0) t_done = k;
      if (k > 0 && !busy1) break;
      @(negedge clk);
    end
    chk("one_words", n, 4);
    chk("one_last_lane", lastpos, 3);
    chk("one_done_at", t_done, 6);
`ifdef STREAM_CHECKSUM_EN
    chk("one_checksum", cks1, sum1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_result_streamer.md
# dot_result_streamer

Drains the dotProduct output SRAM after a computation and serialises its contents onto a single-word valid/ready stream. Each row holds `Para_Deg` results, and the stream emits them one word per beat. This block is the on-chip reader that replaces the file-dump sequence used by the load/compute/write flow. It sits between the output SRAM read port and any downstream consumer, such as a host interface or a result FIFO.

## Interface

Parameters:
- `Addr_Width`, 4: output SRAM address width.
- `Nums_Rows`, 8: number of SRAM rows to drain, starting at address 0. Must be ≥1 and ≤ 2^`Addr_Width`.
- `Para_Deg`, 2: result words per SRAM row.
- `Data_Width_Out`, 16: width of one result word.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begins a drain; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE state.
- `done` out 1: one-cycle pulse after the final word has been handshaken.
- `mem_en_read` out 1: SRAM read enable.
- `mem_read_addr` out `Addr_Width`: SRAM row address.
- `mem_read_data` in `Para_Deg*Data_Width_Out`: SRAM row data, valid one cycle after `mem_en_read`.
- `out_valid` out 1: stream word valid.
- `out_ready` in 1: consumer accepts the word.
- `out_data` out `Data_Width_Out`: stream word.
- `out_last` out 1: marks the final word of the drain.
- `checksum` out `Data_Width_Out`: present only with `STREAM_CHECKSUM_EN` defined.

## Operation

State machine: IDLE → READ → WAIT → SEND → (READ | DONE) → IDLE.
- **IDLE**
  - Outputs are all 0.
  - `start`=1 at an edge moves the block to READ. It also clears the row counter and sets `mem_read_addr`=0.
- **READ** (1 cycle)
  - `mem_en_read`=1 and `mem_read_addr`=row.
  - Next state is WAIT.
- **WAIT** (1 cycle)
  - `mem_en_read`=0. The SRAM presents data in this cycle.
  - At the edge, `mem_read_data` is captured into the row buffer and the lane index is cleared. Next state is SEND.
- **SEND**
  - `out_valid`=1 and `out_data` = row buffer bits [lane*`Data_Width_Out` +: `Data_Width_Out`]. Lane 0 (the least significant slice) is emitted first.
  - A handshake is `out_valid`&`out_ready` at an edge.
    - Not the last lane: lane increments.
    - Last lane and row < `Nums_Rows`-1: row increments and the state goes to READ.
    - Last lane of the last row: the state goes to DONE.
- **DONE** (1 cycle)
  - `done`=1 and `busy`=1. Next state is IDLE.
- `out_last` = SEND & last row & last lane.
- Stream rules:
  - Once asserted, `out_valid` stays high and `out_data` stays stable until the handshake.
  - No word is dropped or duplicated.
  - `out_ready` may be high while `out_valid` is low; this has no effect.
- `start` outside IDLE, including during DONE, is ignored.
- All outputs are registered.

## Timing

- Reset values:
  - State is IDLE.
  - `busy`, `done`, `mem_en_read`, `out_valid`, `out_last` = 0.
  - `mem_read_addr` and `out_data` = 0.
  - Row counter, lane counter and row buffer are cleared.
  - `checksum` = 0.
- `start` accepted at edge T:
  - `mem_en_read` is high in cycle T..T+1.
  - The first `out_valid` is high from edge T+2.
- Per row, with `out_ready` held at 1: 2 + `Para_Deg` cycles.
- A full drain at defaults takes 8×4 = 32 cycles from acceptance to the final handshake. `done` is high in the following cycle, and `busy` falls one cycle after that.
- Reset mid-drain:
  - All outputs return to reset values immediately (asynchronous).
  - The partial drain is abandoned.
  - The next `start` replays from row 0.

## Configuration

`STREAM_CHECKSUM_EN`:
- **Defined:**
  - A `Data_Width_Out`-bit accumulator is cleared when `start` is accepted.
  - It adds every handshaken word modulo 2^`Data_Width_Out`; carries are discarded.
  - `checksum` presents the accumulator. It is final when `done`=1 and holds until the next accepted `start`.
- **Undefined:**
  - The accumulator and the `checksum` port are absent.
  - All other behaviour is identical.

## Test plan

- **Reset:** assert `reset_n`=0 mid-SEND at word 6 → all outputs 0 in the same cycle. Then release reset and pulse `start` → the stream restarts at word 0.
- **Full drain:**
  - Setup: defaults, SRAM row r = {lane1=2r+1, lane0=2r}, `out_ready`=1, `start` accepted at T.
  - Stream: words 0..15 in order, with the first `out_valid` at T+2.
  - Memory port: `mem_read_addr` steps 0..7.
  - End of drain: `out_last` is high only on word 15, `done` is high 1 cycle after it, and `busy` falls 1 cycle after that.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles while word 3 is presented → `out_data`=3 stays stable and `out_valid` stays high.
  - Then toggle `out_ready` 1,0,1,0 → exactly 16 unique words are delivered, in order.
- **Ignored start:** pulse `start` during SEND and again during DONE → no restart, no address change, and a single `done` pulse.
- **Single-row:** with `Nums_Rows`=1 and `Para_Deg`=4 → 4 words, `out_last` on lane 3, and `done` 7 cycles after acceptance.
- **Checksum** (`STREAM_CHECKSUM_EN`):
  - The full-drain data above gives `checksum`=120 at `done`.
  - All words at 16'hFFFF give `checksum`=16'hFFF0 (16 × 0xFFFF mod 2^16).
